pkt_rx_check: RTL and testbench

Receive-side packet checker that sits directly downstream of the data generator wrapper and consumes its sop/vld/data/eop stream. It parses the header beat, counts payload beats against the header length, classifies framing errors, and queues one descriptor per packet in a small FIFO for the cache write path. It has no backpressure toward the generator: every valid beat is accepted.

---
 rtl/pkt_rx_check_pkg.sv | 42 ++++
 rtl/pkt_rx_check_if.sv | 25 ++
 rtl/pkt_rx_check_fifo.sv | 74 +++++++
 rtl/pkt_rx_check.sv | 231 +++++++++++++++++++++++
 tb/tb_pkt_rx_check.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pkt_rx_check_pkg.sv
// Shared definitions for the receive-side packet checker: header field layout,
// error codes, descriptor format, FSM encoding and the payload-beat helper.
package pkt_rx_pkg;

    localparam int DA_LSB   = 0;
    localparam int DA_W     = 4;
    localparam int PRIO_LSB = 4;
    localparam int PRIO_W   = 3;
    localparam int LEN_LSB  = 7;
    localparam int LEN_W    = 10;
    localparam int EXP_W    = 11;
    localparam int DESC_W   = 19;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_SHORT = 2'd1,
        ERR_LONG  = 2'd2,
        ERR_FRAME = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_LONG    = 2'd2
    } state_e;

    typedef struct packed {
        err_e              err;
        logic [LEN_W-1:0]  len;
        logic [PRIO_W-1:0] prior;
        logic [DA_W-1:0]   da;
    } desc_t;

    // Payload bytes rounded up to whole beats; shift is log2 of bytes per beat.
    function automatic logic [EXP_W-1:0] calc_exp(input logic [LEN_W-1:0] len,
                                                  input int unsigned shift);
        logic [31:0] sum;
        sum = 32'(len) + ((32'd1 << shift) - 32'd1);
        return EXP_W'(sum >> shift);
    endfunction

endpackage

// File: rtl/pkt_rx_check_if.sv
// Beat stream from the generator plus the descriptor handshake toward the cache
// write path; master is the driving side, slave is the checker.
interface pkt_rx_check_if
    import pkt_rx_pkg::*;
#(
    parameter int DW = 32
);
    logic              i_sop;
    logic              i_vld;
    logic [DW-1:0]     i_data;
    logic              i_eop;
    logic [DESC_W-1:0] o_desc;
    logic              o_desc_vld;
    logic              i_desc_rdy;

    modport master (
        output i_sop, i_vld, i_data, i_eop, i_desc_rdy,
        input  o_desc, o_desc_vld
    );

    modport slave (
        input  i_sop, i_vld, i_data, i_eop, i_desc_rdy,
        output o_desc, o_desc_vld
    );
endinterface

// File: rtl/pkt_rx_check_fifo.sv
// Synchronous descriptor FIFO with same-cycle push/pop; a push into a full FIFO
// without a matching pop is dropped and flagged one cycle later on ovf.
module pkt_desc_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign ovf      = ovf_q;

    // A pop frees the slot the concurrent push lands in, so full+pop still accepts.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push & full & ~do_pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/pkt_rx_check.sv
// Receive packet checker: header parse, payload beat count, framing classification
// and descriptor queueing. Define PKT_RX_CHECK_STATS_EN to add packet/error counters.
module pkt_rx_check
    import pkt_rx_pkg::*;
#(
    parameter int DW         = 32,
    parameter int DESC_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    pkt_rx_check_if.slave bus,
    output logic          o_ovf,
    output logic          o_busy
`ifdef PKT_RX_CHECK_STATS_EN
    ,
    output logic [15:0]   o_pkt_cnt,
    output logic [15:0]   o_err_cnt
`endif
);
    localparam int unsigned BEAT_SHIFT = $clog2(DW / 8);

    state_e            state_q, state_d;
    logic [EXP_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PRIO_W-1:0] prior_q, prior_d;
    logic [DA_W-1:0]   da_q, da_d;
    desc_t             pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;

    logic [DA_W-1:0]   hdr_da;
    logic [PRIO_W-1:0] hdr_prior;
    logic [LEN_W-1:0]  hdr_len;
    logic [EXP_W-1:0]  hdr_exp;
    logic              start_hdr;
    logic              fin_a_vld, fin_b_vld;
    desc_t             fin_a, fin_b;
    logic              push, pop;
    desc_t             push_desc;
    logic              fifo_full, fifo_empty;
    logic              unused_data;

    assign hdr_da      = bus.i_data[DA_LSB +: DA_W];
    assign hdr_prior   = bus.i_data[PRIO_LSB +: PRIO_W];
    assign hdr_len     = bus.i_data[LEN_LSB +: LEN_W];
    assign hdr_exp     = calc_exp(hdr_len, BEAT_SHIFT);
    assign unused_data = ^bus.i_data[DW-1:LEN_LSB+LEN_W];

    // fin_a closes the packet in flight, fin_b is a new header that also carries eop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        len_d     = len_q;
        prior_d   = prior_q;
        da_d      = da_q;
        start_hdr = 1'b0;
        cnt_inc   = cnt_q + 1'b1;
        fin_a_vld = 1'b0;
        fin_a     = '0;
        fin_a.len   = len_q;
        fin_a.prior = prior_q;
        fin_a.da    = da_q;
        fin_b_vld = 1'b0;
        fin_b     = '0;
        fin_b.len   = hdr_len;
        fin_b.prior = hdr_prior;
        fin_b.da    = hdr_da;
        fin_b.err   = (hdr_exp != '0) ? ERR_SHORT : ERR_OK;

        if (bus.i_vld) begin
            case (state_q)
                ST_IDLE: begin
                    start_hdr = bus.i_sop;
                end
                ST_PAYLOAD: begin
                    if (bus.i_sop) begin
                        fin_a_vld = 1'b1;
                        fin_a.err = ERR_FRAME;
                        start_hdr = 1'b1;
                    end else if (bus.i_eop) begin
                        fin_a_vld = 1'b1;
                        fin_a.err = (cnt_inc == exp_q) ? ERR_OK : ERR_SHORT;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == exp_q) begin
                            state_d = ST_LONG;
                        end
                    end
                end
                ST_LONG: begin
                    if (bus.i_sop) begin
                        fin_a_vld = 1'b1;
                        fin_a.err = ERR_FRAME;
                        start_hdr = 1'b1;
                    end else if (bus.i_eop) begin
                        fin_a_vld = 1'b1;
                        fin_a.err = ERR_LONG;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start_hdr) begin
            if (bus.i_eop) begin
                fin_b_vld = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                len_d   = hdr_len;
                prior_d = hdr_prior;
                da_d    = hdr_da;
                exp_d   = hdr_exp;
                cnt_d   = '0;
                state_d = (hdr_exp == '0) ? ST_LONG : ST_PAYLOAD;
            end
        end
    end

    // A second finish waits one cycle in pend_q. The pend slot can only be busy while
    // the FSM is idle, so it never has to hold more than one descriptor.
    always_comb begin
        push       = 1'b0;
        push_desc  = '0;
        pend_vld_d = 1'b0;
        pend_d     = pend_q;
        if (pend_vld_q) begin
            push      = 1'b1;
            push_desc = pend_q;
            if (fin_a_vld) begin
                pend_vld_d = 1'b1;
                pend_d     = fin_a;
            end else if (fin_b_vld) begin
                pend_vld_d = 1'b1;
                pend_d     = fin_b;
            end
        end else if (fin_a_vld) begin
            push      = 1'b1;
            push_desc = fin_a;
            if (fin_b_vld) begin
                pend_vld_d = 1'b1;
                pend_d     = fin_b;
            end
        end else if (fin_b_vld) begin
            push      = 1'b1;
            push_desc = fin_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            exp_q      <= '0;
            len_q      <= '0;
            prior_q    <= '0;
            da_q       <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            len_q      <= len_d;
            prior_q    <= prior_d;
            da_q       <= da_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign pop            = ~fifo_empty & bus.i_desc_rdy;
    assign bus.o_desc_vld = ~fifo_empty;
    assign o_busy         = (state_q != ST_IDLE);

    pkt_desc_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (DESC_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_desc),
        .pop       (pop),
        .pop_data  (bus.o_desc),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ovf       (o_ovf)
    );

`ifdef PKT_RX_CHECK_STATS_EN
    logic        push_ok;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    assign push_ok = push & (~fifo_full | pop);

    // Only descriptors that actually enter the FIFO are counted; counters saturate.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push_ok) begin
            if (pkt_cnt_q != 16'hFFFF) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
            if (push_desc.err != ERR_OK && err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_pkt_cnt = pkt_cnt_q;
    assign o_err_cnt = err_cnt_q;
`else
    logic unused_full;
    assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_pkt_rx_check.sv
// Directed bench for pkt_rx_check: expected descriptors are queued as packets are
// sent and compared against the FIFO head as it drains.
module tb_pkt_rx_check;
   import pkt_rx_pkg::*;

   localparam int DW         = 32;
   localparam int DESC_DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic o_ovf;
   logic o_busy;
`ifdef PKT_RX_CHECK_STATS_EN
   logic [15:0] o_pkt_cnt;
   logic [15:0] o_err_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [DESC_W-1:0] expQ[$];
   logic [DESC_W-1:0] headDesc;

   pkt_rx_check_if #(.DW(DW)) bus ();

   pkt_rx_check #(
      .DW         (DW),
      .DESC_DEPTH (DESC_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .o_ovf     (o_ovf),
      .o_busy    (o_busy)
`ifdef PKT_RX_CHECK_STATS_EN
      ,
      .o_pkt_cnt (o_pkt_cnt),
      .o_err_cnt (o_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mkHdr(input logic [3:0] da, input logic [2:0] prio,
                                           input logic [9:0] len);
      return {15'h0, len, prio, da};
   endfunction

   function automatic logic [DESC_W-1:0] mkDesc(input logic [1:0] err, input logic [9:0] len,
                                                input logic [2:0] prio, input logic [3:0] da);
      return {err, len, prio, da};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one beat, then step to just after the clock edge that consumes it.
   task automatic applyStimulus(input logic sop, input logic vld, input logic eop,
                                input logic [DW-1:0] data);
      bus.i_sop  = sop;
      bus.i_vld  = vld;
      bus.i_eop  = eop;
      bus.i_data = data;
      @(posedge clk);
      #1;
   endtask

   // Pop everything, compare each head with the scoreboard, then require an empty FIFO.
   task automatic drainCheck(input string tag);
      int guard = 0;
      logic [DESC_W-1:0] expDesc;
      bus.i_desc_rdy = 1'b1;
      while (expQ.size() > 0 && guard < 32) begin
         if (bus.o_desc_vld) begin
            expDesc = expQ.pop_front();
            checkOutput({tag, "_desc"}, 32'(bus.o_desc), 32'(expDesc));
         end
         @(posedge clk);
         #1;
         guard++;
      end
      bus.i_desc_rdy = 1'b0;
      checkOutput({tag, "_missing"}, expQ.size(), 0);
      expQ.delete();
      checkOutput({tag, "_extra"}, bus.o_desc_vld, 0);
   endtask

   initial begin
      bus.i_sop      = 1'b0;
      bus.i_vld      = 1'b0;
      bus.i_eop      = 1'b0;
      bus.i_data     = '0;
      bus.i_desc_rdy = 1'b0;
      rst            = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      checkOutput("reset_busy", o_busy, 0);
      checkOutput("reset_vld", bus.o_desc_vld, 0);
      checkOutput("reset_ovf", o_ovf, 0);
      checkOutput("reset_desc", 32'(bus.o_desc), 0);
      rst = 1'b0;
      applyStimulus(0, 0, 0, '0);

      $display("[TB] good packet");
      applyStimulus(1, 1, 0, mkHdr(4'd5, 3'd2, 10'd8));
      expQ.push_back(mkDesc(ERR_OK, 10'd8, 3'd2, 4'd5));
      checkOutput("good_busy", o_busy, 1);
      applyStimulus(0, 1, 0, 32'h1111_1111);
      checkOutput("good_vld_early", bus.o_desc_vld, 0);
      applyStimulus(0, 1, 1, 32'h2222_2222);
      checkOutput("good_vld_latency", bus.o_desc_vld, 1);
      checkOutput("good_busy_after", o_busy, 0);
      applyStimulus(0, 0, 0, '0);
      drainCheck("good");

      $display("[TB] short and long packets");
      applyStimulus(1, 1, 0, mkHdr(4'd3, 3'd1, 10'd12));
      applyStimulus(0, 1, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h0);
      expQ.push_back(mkDesc(ERR_SHORT, 10'd12, 3'd1, 4'd3));
      applyStimulus(1, 1, 0, mkHdr(4'd7, 3'd6, 10'd4));
      applyStimulus(0, 1, 0, 32'h0);
      checkOutput("long_busy", o_busy, 1);
      applyStimulus(0, 1, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h0);
      expQ.push_back(mkDesc(ERR_LONG, 10'd4, 3'd6, 4'd7));
      applyStimulus(0, 0, 0, '0);
      drainCheck("short_long");

      $display("[TB] framing");
      applyStimulus(1, 1, 0, mkHdr(4'd1, 3'd3, 10'd16));
      applyStimulus(1, 1, 1, mkHdr(4'd6, 3'd1, 10'd0));
      expQ.push_back(mkDesc(ERR_FRAME, 10'd16, 3'd3, 4'd1));
      expQ.push_back(mkDesc(ERR_OK, 10'd0, 3'd1, 4'd6));
      checkOutput("frame_busy", o_busy, 0);
      applyStimulus(0, 0, 0, '0);
      drainCheck("frame");

      $display("[TB] overflow");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 1, 1, mkHdr(4'(k), 3'd0, 10'd0));
         if (k < 4) begin
            expQ.push_back(mkDesc(ERR_OK, 10'd0, 3'd0, 4'(k)));
         end
         checkOutput($sformatf("ovf_beat%0d", k), o_ovf, (k == 4) ? 1 : 0);
      end
      applyStimulus(0, 0, 0, '0);
      checkOutput("ovf_pulse_end", o_ovf, 0);
      bus.i_desc_rdy = 1'b1;
      headDesc = expQ.pop_front();
      checkOutput("ovf_head", 32'(bus.o_desc), 32'(headDesc));
      applyStimulus(1, 1, 1, mkHdr(4'd7, 3'd0, 10'd0));
      expQ.push_back(mkDesc(ERR_OK, 10'd0, 3'd0, 4'd7));
      bus.i_desc_rdy = 1'b0;
      checkOutput("ovf_push_pop", o_ovf, 0);
      applyStimulus(0, 0, 0, '0);
      drainCheck("ovf");

      $display("[TB] reset mid-packet");
      applyStimulus(1, 1, 1, mkHdr(4'd9, 3'd0, 10'd0));
      applyStimulus(1, 1, 0, mkHdr(4'd2, 3'd4, 10'd64));
      bus.i_sop  = 1'b0;
      bus.i_vld  = 1'b1;
      bus.i_eop  = 1'b0;
      bus.i_data = 32'h3333_3333;
      rst        = 1'b1;
      #1;
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_vld", bus.o_desc_vld, 0);
      @(posedge clk);
      #1;
      bus.i_vld = 1'b0;
      rst       = 1'b0;
      applyStimulus(1, 1, 0, mkHdr(4'd3, 3'd1, 10'd8));
      applyStimulus(0, 1, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h0);
      expQ.push_back(mkDesc(ERR_OK, 10'd8, 3'd1, 4'd3));
      applyStimulus(0, 0, 0, '0);
      drainCheck("rst_recover");

      $display("[TB] stray beats and stats");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(0, 1, 0, 32'h0000_0ABC);
      applyStimulus(0, 1, 1, 32'h0000_0DEF);
      applyStimulus(0, 1, 0, 32'h0000_0123);
      checkOutput("stray_busy", o_busy, 0);
      applyStimulus(0, 0, 0, '0);
      drainCheck("stray");
      applyStimulus(1, 1, 1, mkHdr(4'd8, 3'd5, 10'd0));
      expQ.push_back(mkDesc(ERR_OK, 10'd0, 3'd5, 4'd8));
      applyStimulus(1, 1, 0, mkHdr(4'd10, 3'd7, 10'd8));
      applyStimulus(0, 1, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h0);
      expQ.push_back(mkDesc(ERR_OK, 10'd8, 3'd7, 4'd10));
      applyStimulus(1, 1, 1, mkHdr(4'd11, 3'd2, 10'd5));
      expQ.push_back(mkDesc(ERR_SHORT, 10'd5, 3'd2, 4'd11));
      applyStimulus(0, 0, 0, '0);
      drainCheck("stats");
`ifdef PKT_RX_CHECK_STATS_EN
      checkOutput("stats_pkt_cnt", 32'(o_pkt_cnt), 3);
      checkOutput("stats_err_cnt", 32'(o_err_cnt), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
